qix_shared_ram_arbiter: RTL



---
 rtl/qix_pkg.sv | 17 +
 rtl/qix_shared_ram_arbiter_if.sv | 39 +++
 rtl/qix_sp_ram_1k.sv | 28 ++
 rtl/qix_shared_ram_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/qix_pkg.sv
// Shared types and constants for the Qix shared-RAM arbiter slice.
// Slot defaults match the 6809E E/Q phase positions used on the Qix boards.
package qix_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int QIX_DATA_SLOT   = 12;
  localparam int QIX_VID_SLOT    = 13;
  localparam int QIX_HS_SLOT     = 14;
  localparam int QIX_SHRAM_AW    = 10;
  localparam int QIX_SHRAM_DW    = 8;
  localparam int QIX_SHRAM_DEPTH = 1 << QIX_SHRAM_AW;

endpackage

// File: rtl/qix_shared_ram_arbiter_if.sv
// Requester-side bus of the shared RAM: data CPU, video CPU and hiscore port.
// CPUs have no handshake (cs sampled in their slot); hiscore holds hs_req until hs_ack pulses.
interface qix_shared_ram_arbiter_if;
  import qix_pkg::*;

  logic                    data_cs;
  logic                    data_we;
  logic [QIX_SHRAM_AW-1:0] data_addr;
  logic [QIX_SHRAM_DW-1:0] data_din;
  logic [QIX_SHRAM_DW-1:0] data_dout;

  logic                    vid_cs;
  logic                    vid_we;
  logic [QIX_SHRAM_AW-1:0] vid_addr;
  logic [QIX_SHRAM_DW-1:0] vid_din;
  logic [QIX_SHRAM_DW-1:0] vid_dout;

  logic                    hs_req;
  logic                    hs_we;
  logic [QIX_SHRAM_AW-1:0] hs_addr;
  logic [QIX_SHRAM_DW-1:0] hs_din;
  logic [QIX_SHRAM_DW-1:0] hs_dout;
  logic                    hs_ack;

  modport master (
    output data_cs, data_we, data_addr, data_din,
    output vid_cs, vid_we, vid_addr, vid_din,
    output hs_req, hs_we, hs_addr, hs_din,
    input  data_dout, vid_dout, hs_dout, hs_ack
  );

  modport slave (
    input  data_cs, data_we, data_addr, data_din,
    input  vid_cs, vid_we, vid_addr, vid_din,
    input  hs_req, hs_we, hs_addr, hs_din,
    output data_dout, vid_dout, hs_dout, hs_ack
  );

endinterface

// File: rtl/qix_sp_ram_1k.sv
// 1024x8 single-port RAM, registered read, read-before-write on the same address.
module qix_sp_ram_1k
  import qix_pkg::*;
(
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [QIX_SHRAM_AW-1:0] addr,
  input  logic [QIX_SHRAM_DW-1:0] din,
  output logic [QIX_SHRAM_DW-1:0] dout
);

  logic [QIX_SHRAM_DW-1:0] r_mem [0:QIX_SHRAM_DEPTH-1];
  logic [QIX_SHRAM_DW-1:0] r_dout;

  // Both updates are non-blocking, so a write cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      r_dout <= r_mem[addr];
      if (we) begin
        r_mem[addr] <= din;
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/qix_shared_ram_arbiter.sv
// Phase-slotted arbiter sharing one single-port RAM between data CPU, video CPU
// and hiscore port, with a zero-fill of the RAM after reset.
module qix_shared_ram_arbiter
  import qix_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int DATA_SLOT      = QIX_DATA_SLOT,
  parameter int VID_SLOT       = QIX_VID_SLOT,
  parameter int HS_SLOT        = QIX_HS_SLOT
) (
  input  logic                    clk_20m,
  input  logic                    reset,
  input  logic [3:0]              phase,
  qix_shared_ram_arbiter_if.slave bus,
  output logic                    clr_busy,
  output state_t                  dbg_state,
  output logic [QIX_SHRAM_AW-1:0] dbg_clr_cnt
);

  localparam logic [3:0] L_DATA_SLOT = 4'(DATA_SLOT);
  localparam logic [3:0] L_VID_SLOT  = 4'(VID_SLOT);
  localparam logic [3:0] L_HS_SLOT   = 4'(HS_SLOT);
  localparam logic [QIX_SHRAM_AW-1:0] L_CLR_LAST = '1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [QIX_SHRAM_AW-1:0] r_clr_cnt;

  logic                    w_data_hit;
  logic                    w_vid_hit;
  logic                    w_hs_hit;
  logic                    w_ram_en;
  logic                    w_ram_we;
  logic [QIX_SHRAM_AW-1:0] w_ram_addr;
  logic [QIX_SHRAM_DW-1:0] w_ram_din;
  logic [QIX_SHRAM_DW-1:0] w_ram_rdata;

  // r_sel marks which requester owns the RAM output in the cycle after its slot.
  logic [2:0]              r_sel;
  logic [QIX_SHRAM_DW-1:0] r_data_dout;
  logic [QIX_SHRAM_DW-1:0] r_vid_dout;
  logic [QIX_SHRAM_DW-1:0] r_hs_dout;
  logic                    r_hs_ack;

  assign w_data_hit = (r_state == ST_RUN) && (phase == L_DATA_SLOT) && bus.data_cs;
  assign w_vid_hit  = (r_state == ST_RUN) && (phase == L_VID_SLOT)  && bus.vid_cs;
  assign w_hs_hit   = (r_state == ST_RUN) && (phase == L_HS_SLOT)   && bus.hs_req;

  always_ff @(posedge clk_20m) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_din   = '0;
    case (r_state)
      ST_CLEAR: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_cnt;
        if (r_clr_cnt == L_CLR_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_data_hit) begin
          w_ram_en   = 1'b1;
          w_ram_we   = bus.data_we;
          w_ram_addr = bus.data_addr;
          w_ram_din  = bus.data_din;
        end else if (w_vid_hit) begin
          w_ram_en   = 1'b1;
          w_ram_we   = bus.vid_we;
          w_ram_addr = bus.vid_addr;
          w_ram_din  = bus.vid_din;
        end else if (w_hs_hit) begin
          w_ram_en   = 1'b1;
          w_ram_we   = bus.hs_we;
          w_ram_addr = bus.hs_addr;
          w_ram_din  = bus.hs_din;
        end
      end
    endcase
  end

  qix_sp_ram_1k u_ram (
    .clk  (clk_20m),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_rdata)
  );

  // Hold registers load at the end of slot+1; hs_ack rises with the new hs_dout.
  always_ff @(posedge clk_20m) begin
    if (reset) begin
      r_sel       <= '0;
      r_data_dout <= '0;
      r_vid_dout  <= '0;
      r_hs_dout   <= '0;
      r_hs_ack    <= 1'b0;
    end else begin
      r_sel    <= {w_hs_hit, w_vid_hit, w_data_hit};
      r_hs_ack <= r_sel[2];
      if (r_sel[0]) r_data_dout <= w_ram_rdata;
      if (r_sel[1]) r_vid_dout  <= w_ram_rdata;
      if (r_sel[2]) r_hs_dout   <= w_ram_rdata;
    end
  end

  assign bus.data_dout = r_data_dout;
  assign bus.vid_dout  = r_vid_dout;
  assign bus.hs_dout   = r_hs_dout;
  assign bus.hs_ack    = r_hs_ack;
  assign clr_busy      = (r_state == ST_CLEAR);
  assign dbg_state     = r_state;
  assign dbg_clr_cnt   = r_clr_cnt;

endmodule
